// File: rtl/rv_pkg.sv
// Shared defaults and helpers for the register file and its scoreboard.
package rv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    // Accepts up to 64 flags; callers zero-extend narrower vectors.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + 32'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy flags and busy count, with flush > issue > writeback-clear priority.
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    input  logic            iss_valid_i,
    input  logic [AW-1:0]   iss_rd_i,
    input  logic            flush_i,
    output logic [NREG-1:0] busy_o,
    output logic [AW:0]     busy_cnt_o
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;

    // Later assignments win: clear on writeback, set on issue, wipe on flush.
    always_comb begin
        busy_d = busy_q;
        if (we_i) begin
            busy_d[wa_i] = 1'b0;
        end
        if (iss_valid_i && (iss_rd_i != '0)) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
        cnt_d = (AW+1)'(popcount(64'(busy_d)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with x0 hard-wired to zero, two read ports and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data/busy to the read ports.
module regfile_sb
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rr1,
    input  logic [AW-1:0]   rr2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs_q[wa] <= wd;
        end
    end

    regfile_scoreboard #(.NREG(NREG)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we),
        .wa_i        (wa),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .flush_i     (flush),
        .busy_o      (busy_vec),
        .busy_cnt_o  (busy_cnt)
    );

    // Reset masks the read ports so forwarded write data cannot leak out during reset.
    always_comb begin
        rd1   = regs_q[rr1];
        rd2   = regs_q[rr2];
        busy1 = busy_vec[rr1];
        busy2 = busy_vec[rr2];
`ifdef REGFILE_BYPASS_EN
        if (we && (wa == rr1) && (rr1 != '0)) begin
            rd1   = wd;
            busy1 = 1'b0;
        end
        if (we && (wa == rr2) && (rr2 != '0)) begin
            rd2   = wd;
            busy2 = 1'b0;
        end
`endif
        if (!rst) begin
            rd1   = '0;
            rd2   = '0;
            busy1 = 1'b0;
            busy2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes expected read-port values, a monitor checks them.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [AW-1:0]   rr1 = '0, rr2 = '0, wa = '0, iss_rd = '0;
    logic [XLEN-1:0] wd = '0;
    logic            we = 1'b0, iss_valid = 1'b0, flush = 1'b0;
    logic [XLEN-1:0] rd1, rd2;
    logic            busy1, busy2;
    logic [AW:0]     busy_cnt;

    typedef struct {
        string           name;
        logic [XLEN-1:0] rd1;
        logic            b1;
        logic [XLEN-1:0] rd2;
        logic            b2;
        logic [AW:0]     cnt;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk       (clk),
        .rst       (rst),
        .rr1       (rr1),
        .rr2       (rr2),
        .rd1       (rd1),
        .rd2       (rd2),
        .busy1     (busy1),
        .busy2     (busy2),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic w, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                         input logic iv, input logic [AW-1:0] ir, input logic fl,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        we = w; wa = a; wd = d; iss_valid = iv; iss_rd = ir; flush = fl; rr1 = r1; rr2 = r2;
    endtask

    // Queue what the read ports must show at this cycle's falling edge, then move to the next cycle.
    task automatic applyStimulus(input string name, input logic [XLEN-1:0] e1, input logic eb1,
                                 input logic [XLEN-1:0] e2, input logic eb2, input logic [AW:0] ec);
        exp_t e;
        e.name = name; e.rd1 = e1; e.b1 = eb1; e.rd2 = e2; e.b2 = eb2; e.cnt = ec;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        total += 5;
        if (rd1 !== e.rd1) begin
            bad++; $display("[TB] FAIL %s rd1: got %h want %h", e.name, rd1, e.rd1);
        end
        if (busy1 !== e.b1) begin
            bad++; $display("[TB] FAIL %s busy1: got %b want %b", e.name, busy1, e.b1);
        end
        if (rd2 !== e.rd2) begin
            bad++; $display("[TB] FAIL %s rd2: got %h want %h", e.name, rd2, e.rd2);
        end
        if (busy2 !== e.b2) begin
            bad++; $display("[TB] FAIL %s busy2: got %b want %b", e.name, busy2, e.b2);
        end
        if (busy_cnt !== e.cnt) begin
            bad++; $display("[TB] FAIL %s busy_cnt: got %0d want %0d", e.name, busy_cnt, e.cnt);
        end
    endtask

    // Monitor: every falling edge with a pending expectation is a comparison point.
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        int waitCycles;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 5, 7);
        applyStimulus("reset", 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
        applyStimulus("wr_x5", BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0, 0);
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 5, 0);
        applyStimulus("rd_x5_wr_x0", 32'hDEADBEEF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 5, 0);
        applyStimulus("rd_x0", 32'hDEADBEEF, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 7, 0, 7, 0);
        applyStimulus("iss_x7", 0, 0, 0, 0, 0);
        drive(1, 7, 32'h12, 0, 0, 0, 7, 0);
        applyStimulus("busy_x7_wb", BYP ? 32'h12 : 32'h0, BYP ? 1'b0 : 1'b1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 7, 0);
        applyStimulus("after_wb_x7", 32'h12, 0, 0, 0, 0);
        drive(1, 9, 32'h55, 1, 9, 0, 9, 0);
        applyStimulus("iss_wr_x9", BYP ? 32'h55 : 32'h0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 9, 1);
        applyStimulus("x9_state_iss_x1", 32'h55, 1, 0, 0, 1);
        drive(0, 0, 0, 1, 2, 0, 9, 1);
        applyStimulus("iss_x2", 32'h55, 1, 0, 1, 2);
        drive(0, 0, 0, 1, 3, 0, 9, 2);
        applyStimulus("iss_x3", 32'h55, 1, 0, 1, 3);
        drive(1, 3, 32'h33, 1, 4, 1, 3, 4);
        applyStimulus("flush_iss_x4", BYP ? 32'h33 : 32'h0, BYP ? 1'b0 : 1'b1, 0, 0, 4);
        drive(0, 0, 0, 0, 0, 0, 3, 4);
        applyStimulus("after_flush", 32'h33, 0, 0, 0, 0);
        drive(1, 5, 32'h77, 0, 0, 0, 9, 9);
        applyStimulus("wr_nonbusy", 32'h55, 0, 32'h55, 0, 0);
        drive(0, 0, 0, 1, 9, 0, 5, 9);
        applyStimulus("iss_x9", 32'h77, 0, 32'h55, 0, 0);
        drive(0, 0, 0, 1, 9, 0, 9, 9);
        applyStimulus("reiss_x9", 32'h55, 1, 32'h55, 1, 1);
        drive(0, 0, 0, 1, 6, 0, 9, 6);
        applyStimulus("no_double", 32'h55, 1, 0, 0, 1);
        drive(1, 6, 32'hA5, 0, 0, 0, 9, 6);
        applyStimulus("bypass_x6", 32'h55, 1, BYP ? 32'hA5 : 32'h0, BYP ? 1'b0 : 1'b1, 2);
        drive(0, 0, 0, 1, 10, 0, 9, 6);
        applyStimulus("after_x6_iss_x10", 32'h55, 1, 32'hA5, 0, 1);
        drive(0, 0, 0, 1, 11, 0, 9, 10);
        applyStimulus("iss_x11", 32'h55, 1, 0, 1, 2);
        drive(0, 0, 0, 0, 0, 0, 10, 11);
        applyStimulus("three_busy", 0, 1, 0, 1, 3);
        rst = 1'b0;
        drive(1, 5, 32'hCAFE, 1, 12, 0, 5, 9);
        applyStimulus("async_reset", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 5, 6);
        applyStimulus("hold_reset", 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 5, 7);
        applyStimulus("post_reset_a", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 9, 10);
        applyStimulus("post_reset_b", 0, 0, 0, 0, 0);

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            total++; bad++;
            $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
